// File: rtl/step_clk_ctrl.sv
// rtl/step_clk_ctrl.sv - CPU clock-enable controller with HALT/RUN/STEP modes
//
// Ports:
//   clk_i     in   system clock
//   rst_ni    in   asynchronous active-low reset
//   mode_i    in   00 HALT, 01 RUN, 10 STEP, 11 HALT
//   step_i    in   raw push-button, asynchronous, active-high
//   div_i     in   RUN period minus one, in clk_i cycles
//   halt_i    in   CPU halt request
//   cpu_en_o  out  one-cycle advance pulse to the CPU
//   tick_o    out  toggles on every pulse
//   state_o   out  0 IDLE, 1 RUN, 2 STEP, 3 STOPPED
//   cycles_o  out  number of pulses issued, modulo 2^CNT_W
module step_clk_ctrl #(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [1:0]       mode_i,
  input  logic             step_i,
  input  logic [CNT_W-1:0] div_i,
  input  logic             halt_i,
  output logic             cpu_en_o,
  output logic             tick_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] cycles_o
);

  localparam int unsigned      DEB_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    STEP    = 2'd2,
    STOPPED = 2'd3
  } state_t;

  state_t           state, state_next;
  logic             sync1, sync2;
  logic             deb_level, deb_level_q, step_req;
  logic [DEB_W-1:0] deb_cnt;
  logic [CNT_W-1:0] period_cnt, period_cnt_next;
  logic [CNT_W-1:0] cycles;
  logic             pulse, cpu_en, tick;

  // Button path: 2-flop synchronizer, stability debounce, registered rising edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      deb_level   <= 1'b0;
      deb_level_q <= 1'b0;
      step_req    <= 1'b0;
      deb_cnt     <= '0;
    end else begin
      sync1 <= step_i;
      sync2 <= sync1;
      if (sync2 == deb_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        // Level has differed for DEB_CYCLES consecutive cycles: accept it.
        deb_level <= sync2;
        deb_cnt   <= '0;
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
      deb_level_q <= deb_level;
      step_req    <= deb_level & ~deb_level_q;
    end
  end

  // Next-state and pulse decision. A halt request wins over any pulse due on
  // the same edge, and step requests outside STEP are simply not looked at.
  always_comb begin
    state_next      = state;
    period_cnt_next = period_cnt;
    pulse           = 1'b0;
    case (state)
      IDLE: begin
        if (mode_i == 2'b01) begin
          state_next      = RUN;
          period_cnt_next = '0;
        end else if (mode_i == 2'b10) begin
          state_next = STEP;
        end
      end
      RUN: begin
        if (halt_i) begin
          state_next = STOPPED;
        end else if (mode_i != 2'b01) begin
          state_next = IDLE;
        end else if (period_cnt == div_i) begin
          pulse           = 1'b1;
          period_cnt_next = '0;
        end else begin
          // A div_i lowered below the count lets this wrap round to equality.
          period_cnt_next = period_cnt + CNT_W'(1);
        end
      end
      STEP: begin
        if (halt_i) begin
          state_next = STOPPED;
        end else if (mode_i != 2'b10) begin
          state_next = IDLE;
        end else if (step_req) begin
          pulse = 1'b1;
        end
      end
      STOPPED: begin
        if (mode_i == 2'b00 || mode_i == 2'b11) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      period_cnt <= '0;
      cpu_en     <= 1'b0;
      tick       <= 1'b1;
      cycles     <= '0;
    end else begin
      state      <= state_next;
      period_cnt <= period_cnt_next;
      cpu_en     <= pulse;
      tick       <= tick ^ pulse;
      cycles     <= cycles + CNT_W'(pulse);
    end
  end

  assign cpu_en_o = cpu_en;
  assign tick_o   = tick;
  assign state_o  = state;
  assign cycles_o = cycles;

endmodule

// File: tb/tb_step_clk_ctrl.sv
// tb/tb_step_clk_ctrl.sv - randomized scoreboard bench for step_clk_ctrl
module tb_step_clk_ctrl;

  localparam int CNT_W = 4;
  localparam int DEB   = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic             step = 1'b0;
  logic [CNT_W-1:0] div = '0;
  logic             halt = 1'b0;
  logic             cpu_en, tick;
  logic [1:0]       state;
  logic [CNT_W-1:0] cycles;

  step_clk_ctrl #(.CNT_W(CNT_W), .DEB_CYCLES(DEB)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .mode_i   (mode),
    .step_i   (step),
    .div_i    (div),
    .halt_i   (halt),
    .cpu_en_o (cpu_en),
    .tick_o   (tick),
    .state_o  (state),
    .cycles_o (cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               edge_no;
    logic             tick;
    logic [CNT_W-1:0] cycles;
  } pulse_t;

  pulse_t exp_q[$];
  int     checks = 0;
  int     failures = 0;
  int     edge_n = 0;

  // Reference model: state as a plain int, RUN timing as "edge number of
  // the next due pulse", button as sample histories and a stability window.
  int   m_state;
  int   m_due;
  logic m_tick;
  int   m_cycles;
  logic m_level;
  logic raw_hist[$];
  logic s2_hist[$];
  logic lvl_hist[$];

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (edge %0d)", name, act, exp, edge_n);
    end
  endfunction

  function automatic void model_reset();
    m_state  = 0;
    m_due    = 0;
    m_tick   = 1'b1;
    m_cycles = 0;
    m_level  = 1'b0;
    raw_hist = {};
    s2_hist  = {};
    lvl_hist = {};
    repeat (2) raw_hist.push_back(1'b0);
    repeat (DEB) s2_hist.push_back(1'b0);
    repeat (3) lvl_hist.push_back(1'b0);
  endfunction

  function automatic void issue();
    pulse_t p;
    m_tick   = ~m_tick;
    m_cycles = (m_cycles + 1) % (1 << CNT_W);
    p.edge_no = edge_n;
    p.tick    = m_tick;
    p.cycles  = CNT_W'(m_cycles);
    exp_q.push_back(p);
  endfunction

  function automatic void model_edge();
    logic s2_seen, req, all_diff;
    s2_seen = raw_hist[1];                 // step_i sampled two edges ago
    req     = lvl_hist[1] & ~lvl_hist[2];  // level rose two edges ago
    raw_hist.push_front(step);
    void'(raw_hist.pop_back());
    s2_hist.push_front(s2_seen);
    void'(s2_hist.pop_back());
    all_diff = 1'b1;
    for (int i = 0; i < DEB; i++) if (s2_hist[i] == m_level) all_diff = 1'b0;
    if (all_diff) m_level = ~m_level;
    lvl_hist.push_front(m_level);
    void'(lvl_hist.pop_back());

    case (m_state)
      1, 2: begin
        if (halt) m_state = 3;
        else if (m_state == 1) begin
          if (mode != 2'b01) m_state = 0;
          else if (edge_n == m_due) begin
            issue();
            m_due = edge_n + int'(div) + 1;
          end
        end else begin
          if (mode != 2'b10) m_state = 0;
          else if (req) issue();
        end
      end
      3: if (mode == 2'b00 || mode == 2'b11) m_state = 0;
      default: begin
        if (mode == 2'b01) begin
          m_state = 1;
          m_due   = edge_n + int'(div) + 1;
        end else if (mode == 2'b10) m_state = 2;
      end
    endcase
  endfunction

  always @(posedge clk) begin
    edge_n++;
    if (!rst_n) model_reset();
    else model_edge();
  end

  // Monitor: pops the scoreboard whenever the DUT shows a pulse.
  always @(negedge clk) begin
    pulse_t p;
    while (exp_q.size() > 0 && exp_q[0].edge_no < edge_n) begin
      p = exp_q.pop_front();
      chk("missed_pulse cpu_en", 0, 1);
    end
    if (cpu_en) begin
      if (exp_q.size() == 0 || exp_q[0].edge_no != edge_n) begin
        chk("spurious_pulse cpu_en", 1, 0);
      end else begin
        p = exp_q.pop_front();
        chk("pulse_tick", int'(tick), int'(p.tick));
        chk("pulse_cycles", int'(cycles), int'(p.cycles));
      end
    end
    chk("state", int'(state), m_state);
    chk("tick", int'(tick), int'(m_tick));
    chk("cycles", int'(cycles), m_cycles);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_check(input string tag);
    #2 rst_n = 1'b0;
    #1;
    chk({tag, "_rst_cpu_en"}, int'(cpu_en), 0);
    chk({tag, "_rst_tick"}, int'(tick), 1);
    chk({tag, "_rst_state"}, int'(state), 0);
    chk({tag, "_rst_cycles"}, int'(cycles), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int guard;
    cyc(2);
    rst_n = 1'b1;
    chk("reset_state", int'(state), 0);
    chk("reset_tick", int'(tick), 1);

    // RUN, div 3
    div = 4'd3; mode = 2'b01;
    cyc(14);
    mode = 2'b00; cyc(2);

    // STEP: two clean presses, then glitches of 1..3 cycles
    mode = 2'b10; cyc(1);
    for (int k = 0; k < 2; k++) begin
      step = 1'b1; cyc(10);
      step = 1'b0; cyc(10);
    end
    for (int g = 1; g <= 3; g++) begin
      step = 1'b1; cyc(g);
      step = 1'b0; cyc(8);
    end
    chk("step_two_presses_cycles", int'(cycles), 5);

    // Halt raised exactly on the edge a pulse is due
    mode = 2'b00; cyc(1);
    div = 4'd3; mode = 2'b01; cyc(1);
    guard = 0;
    while (!(m_state == 1 && m_due == edge_n + 1) && guard < 50) begin
      cyc(1);
      guard++;
    end
    if (guard >= 50) chk("halt_wait_timeout", guard, 0);
    halt = 1'b1; cyc(1);
    halt = 1'b0;
    chk("halt_state", int'(state), 3);
    chk("halt_no_pulse", int'(cpu_en), 0);
    cyc(5);
    chk("stopped_hold", int'(state), 3);
    mode = 2'b00; cyc(1);
    chk("stopped_to_idle", int'(state), 0);

    // div 0: continuous enable, cycles_o wraps
    div = 4'd0; mode = 2'b01; cyc(22);
    mode = 2'b00; cyc(2);

    // Reset mid-period, then a fresh full period
    div = 4'd5; mode = 2'b01; cyc(4);
    reset_check("mid_period");
    cyc(12);
    mode = 2'b00; cyc(2);

    // Reset mid-debounce while the button stays pressed
    mode = 2'b10; cyc(1);
    step = 1'b1; cyc(3);
    reset_check("mid_debounce");
    cyc(12);
    step = 1'b0; cyc(8);

    // Randomized phases
    for (int it = 0; it < 40; it++) begin
      int r;
      r = $urandom_range(0, 3);
      mode = 2'b00;
      if (r == 0) div = CNT_W'($urandom_range(0, 5));
      cyc(1);
      case (r)
        0: begin
          mode = 2'b01;
          repeat ($urandom_range(3, 20)) begin
            halt = ($urandom_range(0, 15) == 0);
            step = 1'($urandom_range(0, 1));
            cyc(1);
          end
          halt = 1'b0;
        end
        1: begin
          mode = 2'b10;
          repeat ($urandom_range(3, 8)) begin
            step = ~step;
            halt = ($urandom_range(0, 20) == 0);
            cyc($urandom_range(1, 8));
            halt = 1'b0;
          end
        end
        2: begin
          mode = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
          repeat ($urandom_range(5, 15)) begin
            step = 1'($urandom_range(0, 1));
            cyc($urandom_range(1, 6));
          end
        end
        default: begin
          mode = 2'b10; step = 1'b1; cyc(6);
          mode = 2'b00; cyc(4);
          mode = 2'b10; step = 1'b0; cyc(10);
        end
      endcase
    end

    mode = 2'b00; step = 1'b0; halt = 1'b0;
    cyc(10);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
